// File: rtl/gyro_sample_sequencer.sv
// Transaction sequencer for the PmodGYRO (L3G4200D): one CTRL_REG1 write, then X/Y/Z burst reads per tick.
// Define GYRO_ID_CHECK_EN to read and verify WHO_AM_I before configuration.
module gyro_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  CTRL1_VAL  = 8'h0F
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic        XFER_BEGIN,
  input  logic        XFER_END,
  output logic [7:0]  TX_BYTE,
  input  logic [7:0]  RX_BYTE,
  output logic        SS,
  output logic [15:0] X,
  output logic [15:0] Y,
  output logic [15:0] Z,
  output logic        SAMPLE_VALID,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic        ERR
);

  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

`ifdef GYRO_ID_CHECK_EN
  typedef enum logic [2:0] {IDLE, ID_XFER, CFG_XFER, GAP, WAIT_TICK, RD_XFER, HALT} state_t;
  localparam state_t FIRST_XFER = ID_XFER;
`else
  typedef enum logic [2:0] {IDLE, CFG_XFER, GAP, WAIT_TICK, RD_XFER} state_t;
  localparam state_t FIRST_XFER = CFG_XFER;
`endif

  state_t          state_q, state_d;
  logic            ss_q, ss_d;
  logic            begin_q, begin_d;
  logic [7:0]      tx_q, tx_d;
  logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            cfg_q, cfg_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pending_q, pending_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            byte_busy_q, byte_busy_d;
  logic [7:0]      b1_q, b1_d, b2_q, b2_d, b3_q, b3_d, b4_q, b4_d, b5_q, b5_d;
  logic            consume;
  logic            pend_next;
`ifdef GYRO_ID_CHECK_EN
  logic            err_q, err_d;
  logic            id_ok_q, id_ok_d;
  state_t          gap_src_q, gap_src_d;
`endif

  function automatic logic [7:0] byte_for(input state_t s, input logic [2:0] i);
    case (s)
`ifdef GYRO_ID_CHECK_EN
      ID_XFER:  return (i == 3'd0) ? 8'h8F : 8'h00;
`endif
      CFG_XFER: return (i == 3'd0) ? 8'h20 : CTRL1_VAL;
      RD_XFER:  return (i == 3'd0) ? 8'hE8 : 8'h00;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] last_idx(input state_t s);
    return (s == RD_XFER) ? 3'd6 : 3'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    ss_d        = ss_q;
    begin_d     = 1'b0;
    tx_d        = tx_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    valid_d     = 1'b0;
    overrun_d   = overrun_q;
    cfg_d       = cfg_q;
    timer_d     = timer_q;
    gap_cnt_d   = gap_cnt_q;
    idx_d       = idx_q;
    byte_busy_d = byte_busy_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    b3_d        = b3_q;
    b4_d        = b4_q;
    b5_d        = b5_q;
    consume     = 1'b0;
    pend_next   = 1'b0;
`ifdef GYRO_ID_CHECK_EN
    err_d       = err_q;
    id_ok_d     = id_ok_q;
    gap_src_d   = gap_src_q;
`endif

    case (state_q)
      IDLE: begin
        if (START) begin
          if (cfg_q) begin
            state_d = WAIT_TICK;
          end else begin
            state_d     = FIRST_XFER;
            ss_d        = 1'b0;
            idx_d       = '0;
            byte_busy_d = 1'b0;
          end
        end
      end

`ifdef GYRO_ID_CHECK_EN
      ID_XFER,
`endif
      CFG_XFER, RD_XFER: begin
        if (!byte_busy_q) begin
          begin_d     = 1'b1;
          tx_d        = byte_for(state_q, idx_q);
          byte_busy_d = 1'b1;
        end else if (XFER_END) begin
          if (state_q == RD_XFER) begin
            case (idx_q)
              3'd1:    b1_d = RX_BYTE;
              3'd2:    b2_d = RX_BYTE;
              3'd3:    b3_d = RX_BYTE;
              3'd4:    b4_d = RX_BYTE;
              3'd5:    b5_d = RX_BYTE;
              default: ;
            endcase
          end
`ifdef GYRO_ID_CHECK_EN
          if (state_q == ID_XFER && idx_q == 3'd1) id_ok_d = (RX_BYTE == 8'hD3);
`endif
          if (idx_q == last_idx(state_q)) begin
            ss_d        = 1'b1;
            byte_busy_d = 1'b0;
            state_d     = GAP;
            gap_cnt_d   = '0;
`ifdef GYRO_ID_CHECK_EN
            gap_src_d   = state_q;
`endif
            if (state_q == CFG_XFER) cfg_d = 1'b1;
            // Last byte arrives live, so all three words publish on the same edge as SS rising.
            if (state_q == RD_XFER) begin
              x_d     = {b2_q, b1_q};
              y_d     = {b4_q, b3_q};
              z_d     = {RX_BYTE, b5_q};
              valid_d = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            begin_d = 1'b1;
            tx_d    = byte_for(state_q, idx_q + 3'd1);
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
`ifdef GYRO_ID_CHECK_EN
          if (gap_src_q == ID_XFER && !id_ok_q) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else if (!START) begin
            state_d = IDLE;
          end else if (gap_src_q == ID_XFER) begin
            state_d     = CFG_XFER;
            ss_d        = 1'b0;
            idx_d       = '0;
            byte_busy_d = 1'b0;
          end else begin
            state_d = WAIT_TICK;
          end
`else
          state_d = START ? WAIT_TICK : IDLE;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      WAIT_TICK: begin
        if (!START) begin
          state_d = IDLE;
        end else if (pending_q) begin
          consume     = 1'b1;
          state_d     = RD_XFER;
          ss_d        = 1'b0;
          idx_d       = '0;
          byte_busy_d = 1'b0;
        end
      end

      default: ;
    endcase

    // A tick consumed in the same cycle as a wrap leaves the new tick pending.
    pend_next = pending_q & ~consume;
    if (state_q == IDLE) pend_next = 1'b0;
    if (!START || !cfg_q || state_q == IDLE) begin
      timer_d = '0;
    end else if (timer_q == TW'(SAMPLE_DIV - 1)) begin
      timer_d = '0;
      if (pend_next) overrun_d = 1'b1;
      else           pend_next = 1'b1;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    pending_d = pend_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ss_q        <= 1'b1;
      begin_q     <= 1'b0;
      tx_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_q       <= 1'b0;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      byte_busy_q <= 1'b0;
      b1_q        <= '0;
      b2_q        <= '0;
      b3_q        <= '0;
      b4_q        <= '0;
      b5_q        <= '0;
`ifdef GYRO_ID_CHECK_EN
      err_q       <= 1'b0;
      id_ok_q     <= 1'b0;
      gap_src_q   <= IDLE;
`endif
    end else begin
      state_q     <= state_d;
      ss_q        <= ss_d;
      begin_q     <= begin_d;
      tx_q        <= tx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      cfg_q       <= cfg_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      byte_busy_q <= byte_busy_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      b3_q        <= b3_d;
      b4_q        <= b4_d;
      b5_q        <= b5_d;
`ifdef GYRO_ID_CHECK_EN
      err_q       <= err_d;
      id_ok_q     <= id_ok_d;
      gap_src_q   <= gap_src_d;
`endif
    end
  end

  assign SS           = ss_q;
  assign XFER_BEGIN   = begin_q;
  assign TX_BYTE      = tx_q;
  assign X            = x_q;
  assign Y            = y_q;
  assign Z            = z_q;
  assign SAMPLE_VALID = valid_q;
  assign OVERRUN      = overrun_q;
  assign BUSY         = ~ss_q | (state_q == GAP);
`ifdef GYRO_ID_CHECK_EN
  assign ERR          = err_q;
`else
  assign ERR          = 1'b0;
`endif

endmodule

// File: tb/tb_gyro_sample_sequencer.sv
// Scoreboard bench for gyro_sample_sequencer: byte-engine model, expected TX/sample queues, framing monitor.
module tb_gyro_sample_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, XFER_BEGIN, XFER_END, SS, SAMPLE_VALID, BUSY, OVERRUN, ERR;
  logic [7:0]  TX_BYTE, RX_BYTE;
  logic [15:0] X, Y, Z;

  int unsigned n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_tx[$];
  logic [47:0] exp_smp[$];

  int unsigned byte_delay = 8;
  logic [7:0]  rx_add = 8'h00;
  logic [7:0]  id_resp = 8'hD3;
  int unsigned txn_idx = 0;
  logic [7:0]  model_first = 8'h00;
  int unsigned begins_seen = 0, samples_seen = 0, last_gap = 0;

  gyro_sample_sequencer #(.SAMPLE_DIV(64), .GAP_CYCLES(16), .CTRL1_VAL(8'h0F)) dut (
    .CLK(CLK), .RST(RST), .START(START), .XFER_BEGIN(XFER_BEGIN), .XFER_END(XFER_END),
    .TX_BYTE(TX_BYTE), .RX_BYTE(RX_BYTE), .SS(SS), .X(X), .Y(Y), .Z(Z),
    .SAMPLE_VALID(SAMPLE_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Byte engine: END pulses byte_delay cycles after BEGIN; burst RX bytes are k*0x11 + rx_add.
  initial begin : byte_model
    int unsigned cd;
    logic        open;
    XFER_END = 1'b0;
    RX_BYTE  = 8'h00;
    open     = 1'b0;
    cd       = 0;
    forever begin
      @(posedge CLK); #1;
      XFER_END = 1'b0;
      if (RST) begin
        open    = 1'b0;
        txn_idx = 0;
      end else begin
        if (SS) txn_idx = 0;
        if (open) begin
          cd--;
          if (cd == 0) begin
            open = 1'b0;
            XFER_END = 1'b1;
            if (model_first == 8'hE8 && txn_idx >= 1) RX_BYTE = 8'(txn_idx * 17) + rx_add;
            else if (model_first == 8'h8F && txn_idx == 1) RX_BYTE = id_resp;
            else RX_BYTE = 8'h00;
            txn_idx++;
          end
        end else if (XFER_BEGIN) begin
          open = 1'b1;
          cd   = byte_delay;
          if (txn_idx == 0) model_first = TX_BYTE;
        end
      end
    end
  end

  initial begin : monitor
    logic        prev_ss, open, first_in_txn, seen_txn;
    logic [7:0]  held;
    int unsigned hi_run, since_fall;
    prev_ss = 1'b1; open = 1'b0; first_in_txn = 1'b0; seen_txn = 1'b0;
    held = 8'h00; hi_run = 0; since_fall = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        open = 1'b0; seen_txn = 1'b0; hi_run = 0; prev_ss = SS;
        continue;
      end
      if (prev_ss && !SS) begin
        if (seen_txn) begin
          last_gap = hi_run;
          check("ss_gap_min", 48'(hi_run >= 16), 48'd1);
        end
        since_fall = 0;
        first_in_txn = 1'b1;
      end
      if (!prev_ss && SS) hi_run = 0;
      if (XFER_END) open = 1'b0;
      if (XFER_BEGIN) begin
        check("begin_ss_low", 48'(SS), 48'd0);
        check("begin_no_overlap", 48'(open), 48'd0);
        if (first_in_txn) begin
          check("ss_lead", 48'(since_fall), 48'd1);
          first_in_txn = 1'b0;
        end
        if (exp_tx.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_begin: got tx %02h, required no transfer", TX_BYTE);
        end else begin
          check("tx_byte", 48'(TX_BYTE), 48'(exp_tx.pop_front()));
        end
        open = 1'b1; held = TX_BYTE; seen_txn = 1'b1;
        begins_seen++;
      end else if (open) begin
        check("tx_stable", 48'(TX_BYTE), 48'(held));
      end
      if (SAMPLE_VALID) begin
        check("valid_at_ss_rise", 48'({prev_ss, SS}), 48'd1);
        if (exp_smp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_sample: got %04h %04h %04h, required none", X, Y, Z);
        end else begin
          check("sample_xyz", {X, Y, Z}, exp_smp.pop_front());
        end
        samples_seen++;
      end
      if (SS) hi_run++;
      else since_fall++;
      prev_ss = SS;
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic wait_samples(input int unsigned target, input int unsigned budget);
    int unsigned k = 0;
    while (samples_seen < target && k < budget) begin @(posedge CLK); #2; k++; end
    check("sample_wait", 48'(samples_seen >= target), 48'd1);
  endtask

  task automatic wait_begins(input int unsigned target, input int unsigned budget);
    int unsigned k = 0;
    while (begins_seen < target && k < budget) begin @(posedge CLK); #2; k++; end
    check("begin_wait", 48'(begins_seen >= target), 48'd1);
  endtask

  task automatic push_cfg();
`ifdef GYRO_ID_CHECK_EN
    exp_tx.push_back(8'h8F);
    exp_tx.push_back(8'h00);
`endif
    exp_tx.push_back(8'h20);
    exp_tx.push_back(8'h0F);
  endtask

  task automatic push_read(input logic [47:0] xyz);
    exp_tx.push_back(8'hE8);
    repeat (6) exp_tx.push_back(8'h00);
    exp_smp.push_back(xyz);
  endtask

  initial begin : stim
    int unsigned b0, k;
    RST = 1'b1; START = 1'b0;
    cycles(3);
    check("rst_ss", 48'(SS), 48'd1);
    check("rst_begin", 48'(XFER_BEGIN), 48'd0);
    check("rst_tx", 48'(TX_BYTE), 48'd0);
    check("rst_xyz", {X, Y, Z}, 48'd0);
    check("rst_valid", 48'(SAMPLE_VALID), 48'd0);
    check("rst_busy", 48'(BUSY), 48'd0);
    check("rst_overrun", 48'(OVERRUN), 48'd0);
    check("rst_err", 48'(ERR), 48'd0);
    RST = 1'b0;
    cycles(2);

    // Configuration then one burst read
    rx_add = 8'h00;
    push_cfg();
    push_read(48'h2211_4433_6655);
    START = 1'b1;
    wait_samples(1, 2000);
    START = 1'b0;
    cycles(60);
    check("idle_busy_a", 48'(BUSY), 48'd0);
    check("tx_drained_a", 48'(exp_tx.size()), 48'd0);

    // START dropped during byte 4: burst completes and publishes, then idle
    rx_add = 8'h01;
    push_read(48'h2312_4534_6756);
    b0 = begins_seen;
    START = 1'b1;
    wait_begins(b0 + 4, 500);
    START = 1'b0;
    wait_samples(2, 500);
    cycles(200);
    check("idle_busy_b", 48'(BUSY), 48'd0);
    check("tx_drained_b", 48'(exp_tx.size()), 48'd0);
    // Restart resumes reads without rewriting CTRL_REG1
    rx_add = 8'h02;
    push_read(48'h2413_4635_6857);
    START = 1'b1;
    wait_samples(3, 500);
    START = 1'b0;
    cycles(60);

    // RST coincident with the third XFER_END of a burst
    rx_add = 8'h00;
    exp_tx.push_back(8'hE8);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    push_cfg();
    push_read(48'h2211_4433_6655);
    START = 1'b1;
    k = 0;
    while (!(XFER_END && txn_idx == 3 && model_first == 8'hE8) && k < 3000) begin
      @(posedge CLK); #2; k++;
    end
    check("rst_point_reached", 48'(k < 3000), 48'd1);
    RST = 1'b1;
    @(posedge CLK); #2;
    check("midrst_ss", 48'(SS), 48'd1);
    check("midrst_xyz", {X, Y, Z}, 48'd0);
    check("midrst_valid", 48'(SAMPLE_VALID), 48'd0);
    RST = 1'b0;
    wait_samples(4, 2000);
    START = 1'b0;
    cycles(60);
    check("no_overrun_c", 48'(OVERRUN), 48'd0);
    check("tx_drained_c", 48'(exp_tx.size()), 48'd0);

    // Slow byte engine: ticks pile up, OVERRUN sets, a single pending read follows the gap
    byte_delay = 100;
    rx_add = 8'h01;
    push_read(48'h2312_4534_6756);
    push_read(48'h2312_4534_6756);
    b0 = begins_seen;
    START = 1'b1;
    wait_samples(5, 3000);
    wait_begins(b0 + 8, 200);
    check("pending_gap", 48'(last_gap), 48'd17);
    check("overrun_set", 48'(OVERRUN), 48'd1);
    wait_begins(b0 + 9, 300);
    START = 1'b0;
    wait_samples(6, 1500);
    cycles(300);
    check("idle_busy_d", 48'(BUSY), 48'd0);
    check("tx_drained_d", 48'(exp_tx.size()), 48'd0);
    check("smp_drained_d", 48'(exp_smp.size()), 48'd0);

`ifdef GYRO_ID_CHECK_EN
    // Wrong WHO_AM_I: ERR latches, no further transfers
    byte_delay = 8;
    RST = 1'b1;
    cycles(2);
    RST = 1'b0;
    id_resp = 8'hD4;
    exp_tx.push_back(8'h8F);
    exp_tx.push_back(8'h00);
    START = 1'b1;
    cycles(100);
    check("id_err", 48'(ERR), 48'd1);
    b0 = begins_seen;
    cycles(1000);
    check("halt_no_begin", 48'(begins_seen), 48'(b0));
    check("halt_ss", 48'(SS), 48'd1);
    START = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL global_timeout: got no finish, required finish before 3000000");
    $fatal(1);
  end

endmodule
